// File: rtl/wake_pkg.sv
// Shared FSM encoding, hold-length defaults and width helper for the wake_vote block.
// COCOTB_SIM selects the short simulation hold length.
package wake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAKE    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int SUSTAIN_LEN_SYN = 8000000;
  localparam int SUSTAIN_LEN_SIM = 1024;

`ifdef COCOTB_SIM
  localparam int SUSTAIN_LEN_DEF = SUSTAIN_LEN_SIM;
`else
  localparam int SUSTAIN_LEN_DEF = SUSTAIN_LEN_SYN;
`endif

  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/wake_vote_window.sv
// Sliding hit window: shifts one hit per accepted beat, reports the registered
// popcount and a combinational vote on the post-shift window.
module wake_vote_window #(
  parameter int VOTE_WIN    = 4,
  parameter int VOTE_THRESH = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           hit_i,
  input  logic                           shift_i,
  input  logic                           clear_i,
  output logic                           vote_o,
  output logic [$clog2(VOTE_WIN+1)-1:0]  score_o
);

  localparam int SW = $clog2(VOTE_WIN + 1);

  logic [VOTE_WIN-1:0] r_win;
  logic [VOTE_WIN-1:0] w_nxt;

  function automatic logic [SW-1:0] popcnt(input logic [VOTE_WIN-1:0] v);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < VOTE_WIN; i++) s = s + SW'(v[i]);
    return s;
  endfunction

  generate
    if (VOTE_WIN == 1) begin : g_w1
      assign w_nxt = hit_i;
    end else begin : g_wn
      assign w_nxt = {r_win[VOTE_WIN-2:0], hit_i};
    end
  endgenerate

  assign vote_o  = shift_i && (popcnt(w_nxt) >= SW'(VOTE_THRESH));
  assign score_o = popcnt(r_win);

  always_ff @(posedge clk_i) begin
    if (rst_i)        r_win <= '0;
    else if (clear_i) r_win <= '0;
    else if (shift_i) r_win <= w_nxt;
  end

endmodule

// File: rtl/wake_vote.sv
// Wake-word qualifier: vote over a hit window, hold wake, optional refractory period.
// WAKE_VOTE_RETRIGGER_EN: a vote while awake restarts the hold instead of being ignored.
module wake_vote
  import wake_pkg::*;
#(
  parameter int NUM_CLASSES = 3,
  parameter int WAKE_CLASS  = 0,
  parameter int VOTE_WIN    = 4,
  parameter int VOTE_THRESH = 3,
  parameter int SUSTAIN_LEN = SUSTAIN_LEN_DEF,
  parameter int HOLDOFF_LEN = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CLASSES-1:0]         data_i,
  input  logic                           valid_i,
  input  logic                           last_i,
  output logic                           ready_o,
  output logic                           wake_o,
  output logic                           wake_rise_o,
  output logic                           valid_o,
  output logic [$clog2(VOTE_WIN+1)-1:0]  score_o
);

  localparam int CW        = clog2_max(SUSTAIN_LEN, HOLDOFF_LEN);
  localparam int HOLD_LAST = (HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0;

  generate
    if (NUM_CLASSES < 1 || WAKE_CLASS < 0 || WAKE_CLASS >= NUM_CLASSES) begin : g_bad_class
      $fatal(1, "wake_vote: WAKE_CLASS out of range");
    end
    if (VOTE_WIN < 1 || VOTE_WIN > 16) begin : g_bad_win
      $fatal(1, "wake_vote: VOTE_WIN out of range");
    end
    if (VOTE_THRESH < 1 || VOTE_THRESH > VOTE_WIN) begin : g_bad_thresh
      $fatal(1, "wake_vote: VOTE_THRESH out of range");
    end
    if (SUSTAIN_LEN < 2 || HOLDOFF_LEN < 0) begin : g_bad_len
      $fatal(1, "wake_vote: SUSTAIN_LEN/HOLDOFF_LEN out of range");
    end
  endgenerate

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_rise, w_rise_nxt;
  logic            w_vote, w_fsm_clear, w_clear, w_hit;
  logic            w_unused;

  assign w_hit    = data_i[WAKE_CLASS];
  assign w_unused = ^data_i;
  // A closing beat still votes; only the stored window is discarded.
  assign w_clear  = (valid_i && last_i) || w_fsm_clear;

  wake_vote_window #(
    .VOTE_WIN    (VOTE_WIN),
    .VOTE_THRESH (VOTE_THRESH)
  ) u_window (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hit_i   (w_hit),
    .shift_i (valid_i),
    .clear_i (w_clear),
    .vote_o  (w_vote),
    .score_o (score_o)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fsm_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_vote) begin
          w_state_nxt = ST_WAKE;
          w_fsm_clear = 1'b1;
          w_rise_nxt  = 1'b1;
        end
      end
      ST_WAKE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CW'(SUSTAIN_LEN - 1)) begin
          w_state_nxt = (HOLDOFF_LEN > 0) ? ST_HOLDOFF : ST_IDLE;
          w_cnt_nxt   = '0;
        end
`ifdef WAKE_VOTE_RETRIGGER_EN
        if (w_vote) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = '0;
          w_fsm_clear = 1'b1;
        end
`endif
      end
      ST_HOLDOFF: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CW'(HOLD_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  assign ready_o     = ~rst_i;
  assign wake_o      = (r_state == ST_WAKE);
  assign wake_rise_o = r_rise;
  assign valid_o     = valid_i | wake_o;

endmodule

// File: tb/tb_wake_vote.sv
// Directed and random checks of wake_vote against a queue/countdown reference model.
module tb_wake_vote;

  localparam int NC  = 3;
  localparam int WIN = 4;
  localparam int TH  = 3;
  localparam int SUS = 16;
  localparam int HO  = 8;
  localparam int SW  = $clog2(WIN + 1);
`ifdef WAKE_VOTE_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [NC-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_o, wake_o, wake_rise_o, valid_o;
  logic [SW-1:0] score_o;

  wake_vote #(
    .NUM_CLASSES (NC),
    .WAKE_CLASS  (0),
    .VOTE_WIN    (WIN),
    .VOTE_THRESH (TH),
    .SUSTAIN_LEN (SUS),
    .HOLDOFF_LEN (HO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .wake_o      (wake_o),
    .wake_rise_o (wake_rise_o),
    .valid_o     (valid_o),
    .score_o     (score_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int wake_cnt, rise_cnt, max_score;

  // Reference model: recent hits as a queue, wake/holdoff as remaining-cycle countdowns.
  bit hist[$];
  int wake_left = 0;
  int hold_left = 0;
  bit m_rise    = 1'b0;

  function automatic int hist_sum(input bit q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_step(input bit v, input bit h, input bit l, input bit r);
    bit tmp[$];
    bit vote, clr;
    if (r) begin
      hist.delete(); wake_left = 0; hold_left = 0; m_rise = 0;
      return;
    end
    tmp = hist;
    vote = 0;
    if (v) begin
      tmp.push_back(h);
      if (tmp.size() > WIN) void'(tmp.pop_front());
      vote = (hist_sum(tmp) >= TH);
    end
    clr = v && l;
    m_rise = 0;
    if (wake_left > 0) begin
      if (RETRIG && vote) begin
        wake_left = SUS; clr = 1;
      end else begin
        wake_left--;
        if (wake_left == 0) hold_left = HO;
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end else if (vote) begin
      wake_left = SUS; m_rise = 1; clr = 1;
    end
    if (clr) hist.delete();
    else if (v) hist = tmp;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input bit h, input bit l, input bit r);
    rst_i   = r;
    valid_i = v;
    last_i  = l;
    data_i  = NC'($urandom);
    data_i[0] = h;
    @(posedge clk_i);
    model_step(v, h, l, r);
    #1;
    chk("ready_o", int'(ready_o), int'(!r));
    chk("wake_o", int'(wake_o), int'(wake_left > 0));
    chk("wake_rise_o", int'(wake_rise_o), int'(m_rise));
    chk("score_o", int'(score_o), hist_sum(hist));
    chk("valid_o", int'(valid_o), int'(v || (wake_left > 0)));
    wake_cnt += int'(wake_o);
    rise_cnt += int'(wake_rise_o);
    if (int'(score_o) > max_score) max_score = int'(score_o);
  endtask

  task automatic restart();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    wake_cnt = 0; rise_cnt = 0; max_score = 0;
  endtask

  initial begin
    // Reset state
    restart();
    chk("rst_wake", int'(wake_o), 0);
    chk("rst_score", int'(score_o), 0);

    // 1: hits 1,0,1,1 -> rise right after the 4th beat, 16 wake cycles, 8 holdoff
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    chk("t1_no_early_wake", int'(wake_o), 0);
    cyc(1, 1, 0, 0);
    chk("t1_rise", int'(wake_rise_o), 1);
    cyc(0, 0, 0, 0);
    chk("t1_rise_one_cycle", int'(wake_rise_o), 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0);
    chk("t1_wake_len", wake_cnt, SUS);
    chk("t1_rise_cnt", rise_cnt, 1);

    // 2: repeating 1,1,0,0 never reaches threshold
    restart();
    for (int i = 0; i < 40; i++) cyc(1, (i % 4) < 2, 0, 0);
    chk("t2_max_score", max_score, 2);
    chk("t2_no_wake", wake_cnt, 0);

    // 3: last_i clears the window after voting
    restart();
    cyc(1, 1, 0, 0); cyc(1, 1, 1, 0);
    chk("t3_score_after_last", int'(score_o), 0);
    cyc(1, 1, 0, 0);
    chk("t3_score_next", int'(score_o), 1);
    chk("t3_no_wake", wake_cnt, 0);

    // 4: hits in holdoff are ignored but retained in the window
    restart();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("t4_wake", int'(wake_o), 1);
    for (int i = 0; i < 40 && wake_o; i++) cyc(0, 0, 0, 0);
    chk("t4_wake_end", int'(wake_o), 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("t4_no_wake_holdoff", int'(wake_o), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("t4_score_idle", int'(score_o), 4);
    chk("t4_still_idle", int'(wake_o), 0);
    cyc(1, 1, 0, 0);
    chk("t4_rewake", int'(wake_rise_o), 1);

    // 5: qualifying vote at wake counter 10
    restart();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0);
    chk("t5_wake_len", wake_cnt, RETRIG ? 27 : SUS);
    chk("t5_rise_cnt", rise_cnt, 1);

    // 6: reset mid-wake aborts, then normal operation resumes
    restart();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    chk("t6_wake", int'(wake_o), 0);
    chk("t6_score", int'(score_o), 0);
    chk("t6_ready", int'(ready_o), 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("t6_resume_rise", int'(wake_rise_o), 1);

    // Random traffic against the model
    restart();
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
